afifo_drain_ctrl: RTL and testbench
===================================

AFIFO_DRAIN_CTRL -- requirements
Module: afifo_drain_ctrl

Interface
REQ-001 Parameter WIDTH, default 18: FIFO word width in bits.
REQ-002 Parameter LEN_BITS, default 8: width of the block-length field.
REQ-003 clk_i  input  1  read-side clock; same clock as the FIFO rd_clk_i.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse requesting a block transfer; sampled only in IDLE.
REQ-006 len_i  input  LEN_BITS  number of words in the block; sampled together with start_i.
REQ-007 abort_i  input  1  terminates the current block.
REQ-008 fifo_empty_i  input  1  FIFO rempty_o.
REQ-009 fifo_rd_data_i  input  WIDTH  FIFO rd_data_o; valid one clk_i cycle after fifo_rd_en_o.
REQ-010 fifo_rd_en_o  output  1  FIFO read strobe.
REQ-011 m_valid_o  output  1  downstream word valid.
REQ-012 m_data_o  output  WIDTH  downstream word.
REQ-013 m_ready_i  input  1  downstream accept.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse on block completion or abort completion.
REQ-016 aborted_o  output  1  qualifies done_o; high when the block was aborted, held until the next accepted start_i.
REQ-017 remain_o  output  LEN_BITS  words not yet accepted downstream in the current block.

Function
REQ-018 States: IDLE, RUN, FLUSH. Reset enters IDLE.
REQ-019 IDLE->RUN on start_i=1 with len_i!=0; len_i is latched and remain_o is loaded with len_i. A start_i with len_i=0 is ignored: no busy_o and no done_o.
REQ-020 start_i outside IDLE is ignored.
REQ-021 fifo_rd_en_o is 1 only in RUN, with fifo_empty_i=0, reads issued < latched length, and buffer occupancy plus in-flight reads < 2.
REQ-022 Each word returned by the FIFO enters a 2-entry in-order skid buffer one cycle after its fifo_rd_en_o.
REQ-023 m_valid_o is high while the skid buffer is non-empty, and m_data_o is the oldest entry.
REQ-024 While m_valid_o=1 and m_ready_i=0, m_data_o and m_valid_o stay stable.
REQ-025 A handshake (m_valid_o && m_ready_i) decrements remain_o by 1.
REQ-026 Sustained throughput is 1 word/cycle when the FIFO is non-empty and m_ready_i=1.
REQ-027 First-word latency is 1 cycle, counted from the cycle fifo_rd_en_o=1 to the cycle m_valid_o=1.
REQ-028 RUN->IDLE when the final word handshakes (remain_o 1->0); done_o=1 and aborted_o=0 in the next cycle.
REQ-029 abort_i=1 in RUN: stop issuing reads that cycle, discard buffer contents, and go to FLUSH.
REQ-030 FLUSH discards any in-flight read word, then returns to IDLE with done_o=1 and aborted_o=1.
REQ-031 In FLUSH, m_valid_o=0 and fifo_rd_en_o=0.
REQ-032 abort_i in IDLE or FLUSH is ignored.
REQ-033 If abort_i coincides with the final handshake, the completion wins: aborted_o=0.
REQ-034 fifo_empty_i rising mid-block stalls reads only; there is no timeout.
REQ-035 The block never issues more than the latched length of FIFO reads.

Reset
REQ-036 reset_ni=0 forces asynchronously: IDLE, empty skid buffer, remain_o=0, and 0 on fifo_rd_en_o, m_valid_o, busy_o, done_o and aborted_o.
REQ-037 Reset asserted mid-block drops all buffered and in-flight words, and no done_o is generated.
REQ-038 After reset_ni rises, the first start_i is accepted on the following clock edge.

Structure
REQ-039 The shared package afifo_pkg holds the WIDTH default (18), LEN_BITS default (8) and the state enumeration.
REQ-040 The 2-entry skid buffer is a sub-module named skid2, parameterised on WIDTH, with the same clock and reset.

Verification
REQ-041 FIFO preloaded with 0x00001..0x00005, start with len=5, m_ready=1: five consecutive beats in order, remain_o 5->0, one done_o pulse with aborted_o=0, exactly 5 fifo_rd_en_o pulses.
REQ-042 len=4 and m_ready toggling 1,0,0,1,...: no word lost or duplicated, m_data_o stable during stalls, at most 2 outstanding words.
REQ-043 FIFO empty at start (len=3), words written one at a time 10 cycles apart: each word is delivered 1 cycle after its read, and done_o follows the 3rd handshake.
REQ-044 len=8, abort after the 3rd handshake with 2 words buffered: no further beats, FLUSH is entered, done_o=1 with aborted_o=1, no reads after the abort cycle, remain_o=5.
REQ-045 start with len=0 in IDLE: busy_o stays 0 and no done_o; a start_i pulse during RUN leaves the latched length unchanged.
REQ-046 reset_ni=0 mid-block: all outputs read 0 within the same cycle, and a new len=2 block then completes normally.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous-FIFO drain controller: default widths
// and the controller state enumeration.
package afifo_pkg;

    localparam int WIDTH_DEF    = 18;
    localparam int LEN_BITS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/afifo_drain_ctrl_if.sv
// Downstream valid/ready word stream leaving the drain controller.
interface afifo_drain_ctrl_if
    import afifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i;

    modport master (output m_valid_o, output m_data_o, input m_ready_i);
    modport slave  (input m_valid_o, input m_data_o, output m_ready_i);

endinterface

// File: rtl/skid2.sv
// Two-entry in-order skid buffer with fall-through: an arriving word is visible
// on the output in the cycle it arrives when nothing older is stored.
module skid2
    import afifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             stored;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             pop_stored;

    assign stored      = (count_q != 2'd0);
    assign out_valid_o = stored || in_valid_i;
    assign out_data_o  = stored ? mem_q[rd_ptr_q] : in_data_i;
    assign count_o     = count_q;

    // A word accepted in its arrival cycle never touches the storage.
    assign pop        = out_valid_o && out_ready_i;
    assign bypass     = !stored && in_valid_i && out_ready_i;
    assign push       = in_valid_i && !bypass;
    assign pop_stored = pop && stored;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push)       wr_ptr_q <= ~wr_ptr_q;
            if (pop_stored) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop_stored};
        end
    end

    // NOTE: the payload registers carry no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= in_data_i;
    end

endmodule

// File: rtl/afifo_drain_ctrl.sv
// Drains a fixed-length block of words from the read side of an asynchronous
// FIFO into a valid/ready stream, with abort and completion reporting.
module afifo_drain_ctrl
    import afifo_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LEN_BITS = LEN_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic [LEN_BITS-1:0] len_i,
    input  logic                abort_i,
    input  logic                fifo_empty_i,
    input  logic [WIDTH-1:0]    fifo_rd_data_i,
    output logic                fifo_rd_en_o,
    afifo_drain_ctrl_if.master  m,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic [LEN_BITS-1:0] remain_o
);

    state_e              state_q;
    logic [LEN_BITS-1:0] len_q;
    logic [LEN_BITS-1:0] issued_q;
    logic [LEN_BITS-1:0] remain_q;
    logic                inflight_q;
    logic                done_q;
    logic                aborted_q;

    logic                run;
    logic                m_valid;
    logic                handshake;
    logic                finish;
    logic                abort_take;
    logic                rd_en;
    logic                skid_ready;
    logic                skid_valid;
    logic [WIDTH-1:0]    skid_data;
    logic [1:0]          skid_count;
    logic [1:0]          outstanding;

    assign run        = (state_q == ST_RUN);
    assign m_valid    = run && skid_valid;
    assign handshake  = m_valid && m.m_ready_i;
    assign finish     = run && handshake && (remain_q == LEN_BITS'(1));
    assign abort_take = run && abort_i && !finish;

    // The read strobe must see fifo_empty_i in the same cycle, so it stays combinational.
    assign outstanding = skid_count + {1'b0, inflight_q};
    assign rd_en       = run && !abort_i && !fifo_empty_i &&
                         (issued_q < len_q) && (outstanding < 2'd2);
    assign skid_ready  = m.m_ready_i && run;

    skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (abort_take),
        .in_valid_i  (inflight_q),
        .in_data_i   (fifo_rd_data_i),
        .out_ready_i (skid_ready),
        .out_valid_o (skid_valid),
        .out_data_o  (skid_data),
        .count_o     (skid_count)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading last cycle's values here.
            done_q     <= 1'b0;
            inflight_q <= rd_en;
            if (rd_en) issued_q <= issued_q + LEN_BITS'(1);
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        state_q   <= ST_RUN;
                        len_q     <= len_i;
                        remain_q  <= len_i;
                        issued_q  <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (handshake) remain_q <= remain_q - LEN_BITS'(1);
                    if (finish) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (abort_take) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Reads stop in the abort cycle, so at most one cycle is spent here.
                    if (!inflight_q) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m.m_valid_o  = m_valid;
    assign m.m_data_o   = m_valid ? skid_data : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;
    assign remain_o     = remain_q;

endmodule

// File: tb/tb_afifo_drain_ctrl.sv
// Self-checking bench for afifo_drain_ctrl: a queue-based FIFO model, a
// rule-level scoreboard, a vector table and directed corner sequences.
module tb_afifo_drain_ctrl;
    import afifo_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int LB = LEN_BITS_DEF;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          start = 1'b0;
    logic [LB-1:0] len = '0;
    logic          abort = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  rd_data = '0;
    logic          rd_en;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LB-1:0] remain;

    afifo_drain_ctrl_if #(.WIDTH(W)) m_if ();

    afifo_drain_ctrl #(.WIDTH(W), .LEN_BITS(LB)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .start_i        (start),
        .len_i          (len),
        .abort_i        (abort),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (rd_data),
        .fifo_rd_en_o   (rd_en),
        .m              (m_if),
        .busy_o         (busy),
        .done_o         (done),
        .aborted_o      (aborted),
        .remain_o       (remain)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model and stimulus bookkeeping
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] word_ctr = '0;
    bit           pop_pending = 1'b0;
    int           ready_mode = 0;
    int           rdy_cnt = 0;

    // Reference model of the block, stated in terms of words read and accepted
    bit            m_busy = 0, m_flush = 0, m_done = 0, m_abt = 0;
    int            m_len = 0, m_reads = 0;
    logic [LB-1:0] m_rem = '0;
    logic [W-1:0]  pend_q[$];

    int cyc = 0, beats = 0, reads = 0, dones = 0;
    int last_hs_cyc = 0, last_rd_cyc = 0, last_done_cyc = 0, first_hs_cyc = -1;
    int dut_out = 0, max_out = 0;
    bit exp_valid, exp_rd, hs, dut_hs;

    always @(negedge clk) begin
        cyc++;
        if (!reset_ni) begin
            check("rst rd_en", rd_en, 0);
            check("rst m_valid", m_if.m_valid_o, 0);
            check("rst busy", busy, 0);
            check("rst done", done, 0);
            check("rst aborted", aborted, 0);
            check("rst remain", remain, 0);
            m_busy = 0; m_flush = 0; m_done = 0; m_abt = 0; m_rem = '0;
            pend_q.delete();
            pop_pending = 0;
            dut_out = 0;
        end else begin
            exp_valid = m_busy && !m_flush && (pend_q.size() > 0);
            exp_rd = m_busy && !m_flush && !abort && !fifo_empty &&
                     (m_reads < m_len) && (pend_q.size() < 2);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("aborted", aborted, m_abt);
            check("remain", remain, m_rem);
            check("rd_en", rd_en, exp_rd);
            check("m_valid", m_if.m_valid_o, exp_valid);
            if (exp_valid) check("m_data", m_if.m_data_o, pend_q[0]);
            if (done) begin dones++; last_done_cyc = cyc; end
            pop_pending = rd_en;
            if (rd_en) begin reads++; last_rd_cyc = cyc; end
            dut_hs = m_if.m_valid_o && m_if.m_ready_i;
            hs = exp_valid && m_if.m_ready_i;
            if (hs) begin
                beats++;
                last_hs_cyc = cyc;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
            end
            if (!busy) dut_out = 0;
            else dut_out = dut_out + int'(rd_en) - int'(dut_hs);
            if (dut_out > max_out) max_out = dut_out;
            m_done = 0;
            if (m_busy && m_flush) begin
                m_busy = 0; m_flush = 0; m_done = 1; m_abt = 1;
            end else if (m_busy) begin
                if (hs) begin void'(pend_q.pop_front()); m_rem--; end
                if (exp_rd && fifo_q.size() > 0) begin pend_q.push_back(fifo_q[0]); m_reads++; end
                if (hs && m_rem == 0) begin
                    m_busy = 0; m_done = 1;
                end else if (abort) begin
                    m_flush = 1; pend_q.delete();
                end
            end else if (start && len != 0) begin
                m_busy = 1; m_len = int'(len); m_reads = 0; m_rem = len; m_abt = 0;
            end
        end
    end

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
        start = 1'b0;
        abort = 1'b0;
        case (ready_mode)
            0:       m_if.m_ready_i = 1'b1;
            1:       m_if.m_ready_i = (rdy_cnt % 3 == 0);
            2:       m_if.m_ready_i = 1'($urandom_range(0, 1));
            default: m_if.m_ready_i = 1'b0;
        endcase
        rdy_cnt++;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic fifo_write(input logic [W-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_preload(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(word_ctr);
            word_ctr = word_ctr + 1'b1;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dones > d0) begin ok = 1; break; end
        end
        check({name, " done within budget"}, ok, 1);
    endtask

    typedef struct {
        int len;
        int preload;
        int rmode;
        int exp_reads;
        int exp_beats;
        int exp_remain;
        bit exp_aborted;
        int exp_span;
    } vec_t;

    vec_t vecs[6];
    int   r0, b0, d0;
    bit   ok;

    initial begin : main
        vecs[0] = '{len: 5,   preload: 5,   rmode: 0, exp_reads: 5,   exp_beats: 5,   exp_remain: 0, exp_aborted: 0, exp_span: 4};
        vecs[1] = '{len: 4,   preload: 4,   rmode: 1, exp_reads: 4,   exp_beats: 4,   exp_remain: 0, exp_aborted: 0, exp_span: -1};
        vecs[2] = '{len: 1,   preload: 3,   rmode: 0, exp_reads: 1,   exp_beats: 1,   exp_remain: 0, exp_aborted: 0, exp_span: 0};
        vecs[3] = '{len: 3,   preload: 5,   rmode: 1, exp_reads: 3,   exp_beats: 3,   exp_remain: 0, exp_aborted: 0, exp_span: -1};
        vecs[4] = '{len: 6,   preload: 6,   rmode: 2, exp_reads: 6,   exp_beats: 6,   exp_remain: 0, exp_aborted: 0, exp_span: -1};
        vecs[5] = '{len: 255, preload: 255, rmode: 2, exp_reads: 255, exp_beats: 255, exp_remain: 0, exp_aborted: 0, exp_span: -1};

        m_if.m_ready_i = 1'b0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset remain", remain, 0);

        // Start accepted on the first edge after reset release
        fifo_preload(2);
        ready_mode = 0;
        reset_ni = 1'b1;
        start = 1'b1;
        len = 8'd2;
        d0 = dones;
        tick();
        check("start after reset busy", busy, 1);
        check("start after reset remain", remain, 2);
        wait_done(d0, 50, "post-reset block");

        // Vector table
        foreach (vecs[v]) begin
            if (v == 0) word_ctr = 18'h00001;
            fifo_preload(vecs[v].preload);
            ready_mode = vecs[v].rmode;
            rdy_cnt = 0;
            r0 = reads; b0 = beats; d0 = dones;
            first_hs_cyc = -1;
            max_out = 0;
            start = 1'b1;
            len = LB'(vecs[v].len);
            tick();
            wait_done(d0, 4 * vecs[v].len + 40, $sformatf("vec%0d", v));
            repeat (2) tick();
            check($sformatf("vec%0d reads", v), reads - r0, vecs[v].exp_reads);
            check($sformatf("vec%0d beats", v), beats - b0, vecs[v].exp_beats);
            check($sformatf("vec%0d done pulses", v), dones - d0, 1);
            check($sformatf("vec%0d remain", v), remain, vecs[v].exp_remain);
            check($sformatf("vec%0d aborted", v), aborted, vecs[v].exp_aborted);
            check($sformatf("vec%0d outstanding<=2", v), max_out <= 2, 1);
            if (vecs[v].exp_span >= 0)
                check($sformatf("vec%0d beat span", v), last_hs_cyc - first_hs_cyc, vecs[v].exp_span);
        end

        // Empty FIFO at start, words trickle in 10 cycles apart
        fifo_preload(0);
        ready_mode = 0;
        b0 = beats; d0 = dones;
        start = 1'b1;
        len = 8'd3;
        tick();
        for (int k = 0; k < 3; k++) begin
            fifo_write(word_ctr);
            word_ctr = word_ctr + 1'b1;
            repeat (10) tick();
            check($sformatf("trickle beat %0d", k), beats - b0, k + 1);
            check($sformatf("trickle latency %0d", k), last_hs_cyc - last_rd_cyc, 1);
        end
        check("trickle done count", dones - d0, 1);
        check("trickle done after last beat", last_done_cyc - last_hs_cyc, 1);
        check("trickle aborted", aborted, 0);

        // Abort after the 3rd beat with two words held
        fifo_preload(8);
        ready_mode = 0;
        r0 = reads; b0 = beats; d0 = dones;
        start = 1'b1;
        len = 8'd8;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (beats - b0 >= 3) begin ok = 1; break; end
        end
        check("abort: reached 3 beats", ok, 1);
        ready_mode = 3;
        m_if.m_ready_i = 1'b0;
        repeat (3) tick();
        check("abort: reads before abort", reads - r0, 5);
        abort = 1'b1;
        tick();
        check("abort: flush busy", busy, 1);
        check("abort: flush m_valid", m_if.m_valid_o, 0);
        check("abort: flush rd_en", rd_en, 0);
        ready_mode = 0;
        wait_done(d0, 10, "abort");
        repeat (2) tick();
        check("abort: aborted_o", aborted, 1);
        check("abort: remain", remain, 5);
        check("abort: beats", beats - b0, 3);
        check("abort: reads", reads - r0, 5);
        check("abort: done pulses", dones - d0, 1);

        // Zero-length start is ignored; start during RUN does not relatch
        d0 = dones;
        start = 1'b1;
        len = 8'd0;
        tick();
        repeat (3) tick();
        check("len0 busy", busy, 0);
        check("len0 no done", dones - d0, 0);
        check("len0 aborted held", aborted, 1);
        fifo_preload(6);
        ready_mode = 2;
        r0 = reads; b0 = beats; d0 = dones;
        start = 1'b1;
        len = 8'd4;
        tick();
        tick();
        start = 1'b1;
        len = 8'd9;
        wait_done(d0, 60, "restart-ignored");
        repeat (2) tick();
        check("restart-ignored beats", beats - b0, 4);
        check("restart-ignored reads", reads - r0, 4);
        check("restart-ignored aborted", aborted, 0);

        // Reset in the middle of a block
        fifo_preload(6);
        ready_mode = 1;
        d0 = dones;
        start = 1'b1;
        len = 8'd6;
        repeat (5) tick();
        check("midrst was busy", busy, 1);
        reset_ni = 1'b0;
        #1;
        check("midrst rd_en", rd_en, 0);
        check("midrst m_valid", m_if.m_valid_o, 0);
        check("midrst m_data", m_if.m_data_o, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst aborted", aborted, 0);
        check("midrst remain", remain, 0);
        tick();
        reset_ni = 1'b1;
        repeat (3) tick();
        check("midrst no done", dones - d0, 0);
        fifo_preload(2);
        ready_mode = 0;
        b0 = beats; d0 = dones;
        start = 1'b1;
        len = 8'd2;
        tick();
        wait_done(d0, 30, "after reset");
        check("after reset beats", beats - b0, 2);
        check("after reset aborted", aborted, 0);

        // Randomized traffic against the scoreboard
        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            start = 1'b1;
            len = LB'($urandom_range(0, 12));
            for (int i = 0; i < 300; i++) begin
                tick();
                if ($urandom_range(0, 1) == 1) begin
                    fifo_write(word_ctr);
                    word_ctr = word_ctr + 1'b1;
                end
                if ($urandom_range(0, 24) == 0) abort = 1'b1;
                if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    len = LB'($urandom_range(1, 12));
                end
                if (!busy && i > 2) break;
            end
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
